fft_result_streamer: RTL and testbench

FFT_RESULT_STREAMER -- requirements
Module: fft_result_streamer

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_mag_approx.sv | 25 ++
 rtl/fft_result_streamer.sv | 87 ++++++++
 tb/tb_fft_result_streamer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT result streamer.
// Bin layout: [15:8] real, [7:0] imaginary, signed.
package fft_pkg;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  localparam int BIN_W   = 16;
  localparam int BYTE_W  = 8;
  localparam int RAW_LEN = 8;
  localparam int MAG_LEN = 4;

  localparam logic [BYTE_W-1:0] MAG_SAT = 8'hFF;

endpackage

// File: rtl/fft_mag_approx.sv
// |re|+|im| magnitude approximation of one bin.
// Summed at 9 bits, saturated to one byte.
module fft_mag_approx
  import fft_pkg::*;
(
  input  logic [BIN_W-1:0]  i_bin,
  output logic [BYTE_W-1:0] o_mag
);

  logic [8:0] w_re;
  logic [8:0] w_im;
  logic [8:0] w_abs_re;
  logic [8:0] w_abs_im;
  logic [8:0] w_sum;

  // Sign-extend to 9 bits first so |-128| = 128 fits.
  assign w_re     = {i_bin[15], i_bin[15:8]};
  assign w_im     = {i_bin[7], i_bin[7:0]};
  assign w_abs_re = w_re[8] ? (9'd0 - w_re) : w_re;
  assign w_abs_im = w_im[8] ? (9'd0 - w_im) : w_im;
  assign w_sum    = w_abs_re + w_abs_im;

  assign o_mag = w_sum[8] ? MAG_SAT : w_sum[7:0];

endmodule

// File: rtl/fft_result_streamer.sv
// Latches four FFT bins on done_in and streams them as
// raw re/im bytes or saturated magnitudes over valid/ready.
module fft_result_streamer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              done_in,
  input  logic [BIN_W-1:0]  freq0_in,
  input  logic [BIN_W-1:0]  freq1_in,
  input  logic [BIN_W-1:0]  freq2_in,
  input  logic [BIN_W-1:0]  freq3_in,
  input  logic              mode_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [1:0]        out_bin,
  output logic              out_last,
  output logic              busy,
  output logic              drop_pulse
);

  state_t                  r_state;
  logic [3:0][BIN_W-1:0]   r_bins;
  logic                    r_mode;
  logic [2:0]              r_idx;
  logic                    r_drop;

  logic                    w_valid;
  logic [1:0]              w_bin_idx;
  logic [BIN_W-1:0]        w_sel;
  logic [BYTE_W-1:0]       w_mag;
  logic [BYTE_W-1:0]       w_raw;
  logic                    w_last;
  logic                    w_xfer;
  logic                    w_end;
  logic                    w_capture;

  assign w_valid   = (r_state == S_STREAM);
  assign w_bin_idx = r_mode ? r_idx[1:0] : r_idx[2:1];
  assign w_sel     = r_bins[w_bin_idx];
  assign w_raw     = r_idx[0] ? w_sel[7:0] : w_sel[15:8];
  assign w_last    = r_mode ? (r_idx == 3'(MAG_LEN - 1))
                            : (r_idx == 3'(RAW_LEN - 1));

  assign w_xfer    = w_valid & out_ready & ena;
  assign w_end     = w_xfer & w_last;
  // A new frame is taken when idle or exactly as the old one drains.
  assign w_capture = ena & done_in & (!w_valid | w_end);

  fft_mag_approx u_mag (
    .i_bin (w_sel),
    .o_mag (w_mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bins  <= '0;
      r_mode  <= 1'b0;
      r_idx   <= '0;
      r_drop  <= 1'b0;
    end else if (ena) begin
      r_drop <= done_in & w_valid & !w_end;
      if (w_capture) begin
        r_state <= S_STREAM;
        r_bins  <= {freq3_in, freq2_in, freq1_in, freq0_in};
        r_mode  <= mode_in;
        r_idx   <= '0;
      end else if (w_end) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  assign out_valid  = w_valid;
  assign busy       = w_valid;
  assign drop_pulse = r_drop;
  assign out_data   = w_valid ? (r_mode ? w_mag : w_raw) : '0;
  assign out_bin    = w_valid ? w_bin_idx : 2'd0;
  assign out_last   = w_valid & w_last;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Self-checking bench for fft_result_streamer against a
// frame-level reference model of the byte stream.
module tb_fft_result_streamer;

  typedef logic [15:0] bins_t [4];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        done_in = 1'b0;
  logic [15:0] f0 = '0, f1 = '0, f2 = '0, f3 = '0;
  logic        mode_in = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_bin;
  logic        out_last;
  logic        busy;
  logic        drop_pulse;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fft_result_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .done_in    (done_in),
    .freq0_in   (f0),
    .freq1_in   (f1),
    .freq2_in   (f2),
    .freq3_in   (f3),
    .mode_in    (mode_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bin    (out_bin),
    .out_last   (out_last),
    .busy       (busy),
    .drop_pulse (drop_pulse)
  );

  function automatic logic [7:0] mag_ref(logic [15:0] b);
    int re, im, m;
    re = int'($signed(b[15:8]));
    im = int'($signed(b[7:0]));
    m  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
    if (m > 255) m = 255;
    return 8'(m);
  endfunction

  function automatic int flen(bit m);
    return m ? 4 : 8;
  endfunction

  function automatic logic [7:0] exp_byte(bins_t b, bit m, int k);
    if (m) return mag_ref(b[k]);
    if (k % 2 == 0) return b[k/2][15:8];
    return b[k/2][7:0];
  endfunction

  function automatic logic [1:0] exp_bin(bit m, int k);
    return m ? 2'(k) : 2'(k / 2);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bins(bins_t b, bit m);
    f0 = b[0]; f1 = b[1]; f2 = b[2]; f3 = b[3];
    mode_in = m;
  endtask

  task automatic pulse_done(bins_t b, bit m);
    set_bins(b, m);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    f0 = 16'hDEAD; f1 = 16'hBEEF; f2 = 16'h1234; f3 = 16'h5678;
    mode_in = ~m;
  endtask

  function automatic bins_t rand_bins();
    bins_t b;
    for (int i = 0; i < 4; i++) b[i] = 16'($urandom);
    return b;
  endfunction

  task automatic test_reset;
    total++;
    if ({out_valid, busy, drop_pulse, out_data, out_bin, out_last} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b data=%h bin=%0d last=%b want all 0",
               out_valid, busy, drop_pulse, out_data, out_bin, out_last);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_raw;
    bins_t b = '{16'h05FB, 16'h0000, 16'h0000, 16'h0000};
    logic [7:0] want [8] = '{8'h05, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    out_ready = 1'b1;
    pulse_done(b, 1'b0);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== want[k] ||
          out_bin !== 2'(k / 2) || out_last !== (k == 7)) begin
        bad++;
        $display("FAIL raw_byte%0d: got v=%b busy=%b data=%h bin=%0d last=%b want 1 1 %h %0d %b",
                 k, out_valid, busy, out_data, out_bin, out_last, want[k], k / 2, k == 7);
      end
      tick();
    end
    total++;
    if ({out_valid, busy, out_data, out_bin, out_last} !== '0) begin
      bad++;
      $display("FAIL raw_idle: got v=%b busy=%b data=%h bin=%0d last=%b want zeros",
               out_valid, busy, out_data, out_bin, out_last);
    end
  endtask

  task automatic test_mag;
    bins_t b = '{16'h05FB, 16'h8080, 16'h7F00, 16'hFF01};
    logic [7:0] want [4] = '{8'h0A, 8'hFF, 8'h7F, 8'h02};
    out_ready = 1'b1;
    pulse_done(b, 1'b1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== want[k] ||
          out_bin !== 2'(k) || out_last !== (k == 3)) begin
        bad++;
        $display("FAIL mag_byte%0d: got v=%b data=%h bin=%0d last=%b want 1 %h %0d %b",
                 k, out_valid, out_data, out_bin, out_last, want[k], k, k == 3);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mag_idle: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    bins_t b = rand_bins();
    b[0][15:8] = 8'h05;
    out_ready = 1'b0;
    pulse_done(b, 1'b0);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h05 || out_bin !== 2'd0) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b data=%h bin=%0d want 1 05 0",
                 c, out_valid, out_data, out_bin);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_byte(b, 1'b0, k) ||
          out_last !== (k == 7)) begin
        bad++;
        $display("FAIL bp_byte%0d: got v=%b data=%h last=%b want 1 %h %b",
                 k, out_valid, out_data, out_last, exp_byte(b, 1'b0, k), k == 7);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_overlap;
    bins_t a = rand_bins();
    bins_t b = rand_bins();
    bins_t c = rand_bins();
    out_ready = 1'b1;
    pulse_done(a, 1'b0);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_byte(a, 1'b0, k) ||
          out_bin !== exp_bin(1'b0, k)) begin
        bad++;
        $display("FAIL ovl_a%0d: got v=%b data=%h bin=%0d want 1 %h %0d",
                 k, out_valid, out_data, out_bin, exp_byte(a, 1'b0, k), exp_bin(1'b0, k));
      end
      if (k == 2) begin
        set_bins(b, 1'b1);
        done_in = 1'b1;
      end
      if (k == 7) begin
        set_bins(c, 1'b0);
        done_in = 1'b1;
      end
      tick();
      done_in = 1'b0;
      total++;
      if (drop_pulse !== (k == 2)) begin
        bad++;
        $display("FAIL ovl_drop%0d: got %b want %b", k, drop_pulse, k == 2);
      end
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_byte(c, 1'b0, k) ||
          out_last !== (k == 7)) begin
        bad++;
        $display("FAIL ovl_c%0d: got v=%b data=%h last=%b want 1 %h %b",
                 k, out_valid, out_data, out_last, exp_byte(c, 1'b0, k), k == 7);
      end
      tick();
    end
  endtask

  task automatic test_ena;
    bins_t b = rand_bins();
    out_ready = 1'b1;
    pulse_done(b, 1'b0);
    tick();
    tick();
    ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_byte(b, 1'b0, 2) || out_bin !== 2'd1) begin
        bad++;
        $display("FAIL ena_hold%0d: got v=%b data=%h bin=%0d want 1 %h 1",
                 c, out_valid, out_data, out_bin, exp_byte(b, 1'b0, 2));
      end
    end
    ena = 1'b1;
    for (int k = 2; k < 8; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_byte(b, 1'b0, k)) begin
        bad++;
        $display("FAIL ena_byte%0d: got v=%b data=%h want 1 %h",
                 k, out_valid, out_data, exp_byte(b, 1'b0, k));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    bins_t a = rand_bins();
    bins_t b = rand_bins();
    out_ready = 1'b1;
    pulse_done(a, 1'b0);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, drop_pulse, out_data, out_bin, out_last} !== '0) begin
      bad++;
      $display("FAIL rst_async: got v=%b b=%b d=%b data=%h bin=%0d last=%b want all 0",
               out_valid, busy, drop_pulse, out_data, out_bin, out_last);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_done(b, 1'b1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_byte(b, 1'b1, k) ||
          out_bin !== 2'(k) || out_last !== (k == 3)) begin
        bad++;
        $display("FAIL rst_fresh%0d: got v=%b data=%h bin=%0d last=%b want 1 %h %0d %b",
                 k, out_valid, out_data, out_bin, out_last, exp_byte(b, 1'b1, k), k, k == 3);
      end
      tick();
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) begin
      bins_t b = rand_bins();
      bit m = 1'($urandom);
      int k = 0;
      int cyc = 0;
      out_ready = 1'b0;
      pulse_done(b, m);
      while (k < flen(m) && cyc < 200) begin
        out_ready = 1'($urandom_range(0, 2) != 0);
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_byte(b, m, k) ||
            out_bin !== exp_bin(m, k) || out_last !== (k == flen(m) - 1)) begin
          bad++;
          $display("FAIL rnd%0d_byte%0d: got v=%b data=%h bin=%0d last=%b want 1 %h %0d %b",
                   n, k, out_valid, out_data, out_bin, out_last,
                   exp_byte(b, m, k), exp_bin(m, k), k == flen(m) - 1);
        end
        if (out_ready) k++;
        tick();
        cyc++;
      end
      total++;
      if (cyc >= 200 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_end: got v=%b cycles=%0d want 0 within 200", n, out_valid, cyc);
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_raw();
    test_mag();
    test_backpressure();
    test_overlap();
    test_ena();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
